// File: rtl/pe_mac_sequencer_if.sv
// ----------------------------------------------------------------------------
// pe_mac_sequencer_if
// Bundles the command, operand, result and PE-side signals of one
// pe_mac_sequencer.
//   master : sequencer view (drives cmd_ready, op_ready, res_*, busy, pe_*)
//   slave  : environment view (command source, operand fetch, result sink, PE)
// Ports carried:
//   cmd_valid/cmd_ready/cmd_len        command handshake + vector length
//   op_valid/op_ready/op_a/op_b        operand-pair stream
//   res_valid/res_ready/res_data/res_err  result handshake
//   busy                               high outside IDLE
//   pe_reset/pe_start/pe_ack/pe_a/pe_b PE controls and operands
//   pe_ready/pe_s                      PE status and accumulator value
// ----------------------------------------------------------------------------
interface pe_mac_sequencer_if #(
   parameter int unsigned PRECISION        = 8,
   parameter int unsigned OUTPUT_PRECISION = 32,
   parameter int unsigned LEN_W            = 8
) ();
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [LEN_W-1:0]            cmd_len;
   logic                        op_valid;
   logic                        op_ready;
   logic [PRECISION-1:0]        op_a;
   logic [PRECISION-1:0]        op_b;
   logic                        res_valid;
   logic                        res_ready;
   logic [OUTPUT_PRECISION-1:0] res_data;
   logic                        res_err;
   logic                        busy;
   logic                        pe_reset;
   logic                        pe_start;
   logic [PRECISION-1:0]        pe_a;
   logic [PRECISION-1:0]        pe_b;
   logic                        pe_ready;
   logic                        pe_ack;
   logic [OUTPUT_PRECISION-1:0] pe_s;

   modport master (
      input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready, pe_ready, pe_s,
      output cmd_ready, op_ready, res_valid, res_data, res_err, busy,
             pe_reset, pe_start, pe_a, pe_b, pe_ack
   );

   modport slave (
      output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready, pe_ready, pe_s,
      input  cmd_ready, op_ready, res_valid, res_data, res_err, busy,
             pe_reset, pe_start, pe_a, pe_b, pe_ack
   );
endinterface

// File: rtl/pe_mac_sequencer.sv
// ----------------------------------------------------------------------------
// pe_mac_sequencer
// Runs one dot product of cmd_len operand pairs through a single MAC PE:
// clears the PE, streams operand pairs into it one at a time, completes the
// PE ready/ack handshake for every operation and returns the final sum (or a
// timeout error) on a valid/ready result port.
// Ports:
//   CLK    clock, rising edge
//   reset  synchronous active-high reset
//   bus    pe_mac_sequencer_if.master (command, operand, result, PE signals)
// ----------------------------------------------------------------------------
module pe_mac_sequencer #(
   parameter int unsigned PRECISION        = 8,
   parameter int unsigned OUTPUT_PRECISION = 32,
   parameter int unsigned LEN_W            = 8,
   parameter int unsigned TIMEOUT          = 16
) (
   input logic                CLK,
   input logic                reset,
   pe_mac_sequencer_if.master bus
);

   localparam int unsigned     TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_CLR_WAIT,
      S_CLR_ACK,
      S_FETCH,
      S_MAC,
      S_WAIT,
      S_ACK,
      S_RESULT
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;

   logic [LEN_W-1:0]            r_len;
   logic [LEN_W-1:0]            r_count;
   logic [LEN_W-1:0]            w_count_inc;
   logic [TW-1:0]               r_timer;
   logic [OUTPUT_PRECISION-1:0] r_res_data;
   logic                        r_res_err;
   logic [PRECISION-1:0]        r_pe_a;
   logic [PRECISION-1:0]        r_pe_b;

   logic w_cmd_ready, w_op_ready, w_res_valid;
   logic w_pe_reset, w_pe_start, w_pe_ack;
   logic w_accept, w_take, w_capture, w_timeout, w_res_done;
   logic w_timer_clr, w_timer_inc, w_tmo_hit;

   assign w_count_inc = r_count + LEN_W'(1);
   assign w_tmo_hit   = (r_timer == TMO_LAST);

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = 1'b0;
      w_op_ready  = 1'b0;
      w_res_valid = 1'b0;
      w_pe_reset  = 1'b0;
      w_pe_start  = 1'b0;
      w_pe_ack    = 1'b0;
      w_accept    = 1'b0;
      w_take      = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_res_done  = 1'b0;
      w_timer_clr = 1'b0;
      w_timer_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               w_accept    = 1'b1;
               w_timer_clr = 1'b1;
               w_state_nxt = S_CLR;
            end
         end
         S_CLR: begin
            w_pe_reset  = 1'b1;
            w_timer_clr = 1'b1;
            w_state_nxt = S_CLR_WAIT;
         end
         S_CLR_WAIT: begin
            if (bus.pe_ready) begin
               w_state_nxt = S_CLR_ACK;
            end else if (w_tmo_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_RESULT;
            end else begin
               w_timer_inc = 1'b1;
            end
         end
         S_CLR_ACK: begin
            w_pe_ack    = 1'b1;
            w_state_nxt = (r_len == '0) ? S_RESULT : S_FETCH;
         end
         S_FETCH: begin
            w_op_ready = 1'b1;
            if (bus.op_valid) begin
               w_take      = 1'b1;
               w_state_nxt = S_MAC;
            end
         end
         S_MAC: begin
            w_pe_start  = 1'b1;
            w_timer_clr = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.pe_ready) begin
               w_state_nxt = S_ACK;
            end else if (w_tmo_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_RESULT;
            end else begin
               w_timer_inc = 1'b1;
            end
         end
         S_ACK: begin
            w_pe_ack    = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = (w_count_inc == r_len) ? S_RESULT : S_FETCH;
         end
         S_RESULT: begin
            w_res_valid = 1'b1;
            if (bus.res_ready) begin
               w_res_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // res_data is cleared on command accept, so a CLR_WAIT timeout or an
   // empty vector reports 0 and a WAIT timeout reports the last captured sum.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_len      <= '0;
         r_count    <= '0;
         r_timer    <= '0;
         r_res_data <= '0;
         r_res_err  <= 1'b0;
         r_pe_a     <= '0;
         r_pe_b     <= '0;
      end else begin
         if (w_accept) begin
            r_len      <= bus.cmd_len;
            r_count    <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
         end
         if (w_timer_clr) begin
            r_timer <= '0;
         end else if (w_timer_inc) begin
            r_timer <= r_timer + TW'(1);
         end
         if (w_take) begin
            r_pe_a <= bus.op_a;
            r_pe_b <= bus.op_b;
         end
         if (w_capture) begin
            r_res_data <= bus.pe_s;
            r_count    <= w_count_inc;
         end
         if (w_timeout) begin
            r_res_err <= 1'b1;
         end else if (w_res_done) begin
            r_res_err <= 1'b0;
         end
      end
   end

   // Outputs are forced to 0 for the whole time reset is high, not only
   // from the first reset edge onward.
   assign bus.cmd_ready = w_cmd_ready & ~reset;
   assign bus.op_ready  = w_op_ready  & ~reset;
   assign bus.res_valid = w_res_valid & ~reset;
   assign bus.pe_reset  = w_pe_reset  & ~reset;
   assign bus.pe_start  = w_pe_start  & ~reset;
   assign bus.pe_ack    = w_pe_ack    & ~reset;
   assign bus.busy      = (r_state != S_IDLE) & ~reset;
   assign bus.res_err   = r_res_err & ~reset;
   assign bus.res_data  = reset ? '0 : r_res_data;
   assign bus.pe_a      = reset ? '0 : r_pe_a;
   assign bus.pe_b      = reset ? '0 : r_pe_b;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pe_mac_sequencer
// Drives pe_mac_sequencer with directed and random dot-product jobs against a
// behavioural PE model; expected sums come from plain modular arithmetic over
// the operand tables, expected latencies from the cycle budget per element.
// ----------------------------------------------------------------------------
module tb_pe_mac_sequencer;

   localparam int unsigned TMO = 16;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   always #5 CLK = ~CLK;

   pe_mac_sequencer_if #(.PRECISION(8), .OUTPUT_PRECISION(32), .LEN_W(8)) bus ();

   pe_mac_sequencer #(
      .PRECISION(8), .OUTPUT_PRECISION(32), .LEN_W(8), .TIMEOUT(TMO)
   ) dut (
      .CLK(CLK), .reset(reset), .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- PE model ----------------
   int unsigned  pe_lat = 1;        // cycles from pulse to ready
   int unsigned  pe_dead = 0;       // 1: no ready after start, 2: no ready after reset
   logic         preset_en = 1'b0;  // clear loads preset_val instead of 0
   logic [31:0]  preset_val = '0;
   logic [31:0]  pe_acc = '0;
   logic         pe_rdy = 1'b0;
   logic         pe_pend = 1'b0;
   int unsigned  pe_cnt = 0;

   assign bus.pe_ready = pe_rdy;
   assign bus.pe_s     = pe_acc;

   always @(posedge CLK) begin
      if (bus.pe_ack) begin
         pe_rdy  <= 1'b0;
         pe_pend <= 1'b0;
      end else if (bus.pe_reset || bus.pe_start) begin
         if (bus.pe_reset) pe_acc <= preset_en ? preset_val : 32'd0;
         else              pe_acc <= pe_acc + 32'(bus.pe_a) * 32'(bus.pe_b);
         pe_rdy  <= 1'b0;
         pe_pend <= 1'b0;
         if (!((pe_dead == 1 && bus.pe_start) || (pe_dead == 2 && bus.pe_reset))) begin
            if (pe_lat <= 1) pe_rdy <= 1'b1;
            else begin
               pe_pend <= 1'b1;
               pe_cnt  <= pe_lat - 2;
            end
         end
      end else if (pe_pend) begin
         if (pe_cnt == 0) begin
            pe_rdy  <= 1'b1;
            pe_pend <= 1'b0;
         end else begin
            pe_cnt <= pe_cnt - 1;
         end
      end
   end

   // ---------------- event counters and protocol monitor ----------------
   int   cnt_start = 0, cnt_ack = 0, cnt_reset = 0, cnt_opr = 0;
   logic prev_start = 1'b0, prev_ack = 1'b0, prev_rst = 1'b0;
   logic [7:0] exp_pa = '0, exp_pb = '0;

   always @(posedge CLK) begin
      if (bus.pe_start) cnt_start <= cnt_start + 1;
      if (bus.pe_ack)   cnt_ack   <= cnt_ack + 1;
      if (bus.pe_reset) cnt_reset <= cnt_reset + 1;
      if (bus.op_ready) cnt_opr   <= cnt_opr + 1;
      prev_start <= bus.pe_start;
      prev_ack   <= bus.pe_ack;
      prev_rst   <= bus.pe_reset;
      if (reset) begin
         exp_pa <= '0;
         exp_pb <= '0;
      end else if (bus.op_valid && bus.op_ready) begin
         exp_pa <= bus.op_a;
         exp_pb <= bus.op_b;
      end
   end

   always @(negedge CLK) begin
      if (!reset) begin
         if (bus.pe_ack || bus.pe_start || bus.pe_reset)
            check_eq("pe_onehot", 64'($countones({bus.pe_ack, bus.pe_start, bus.pe_reset})), 1);
         if (bus.pe_start) check_eq("start_pulse", prev_start, 0);
         if (bus.pe_ack)   check_eq("ack_pulse", prev_ack, 0);
         if (bus.pe_reset) check_eq("reset_pulse", prev_rst, 0);
         if (bus.pe_start || bus.pe_ack) begin
            check_eq("pe_a_hold", bus.pe_a, exp_pa);
            check_eq("pe_b_hold", bus.pe_b, exp_pb);
         end
         if (bus.cmd_ready || bus.op_ready || bus.res_valid)
            check_eq("ready_onehot", 64'($countones({bus.cmd_ready, bus.op_ready, bus.res_valid})), 1);
         if (bus.cmd_ready) check_eq("idle_not_busy", bus.busy, 0);
         if (bus.op_ready)  check_eq("fetch_busy", bus.busy, 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] qa [256];
   logic [7:0] qb [256];

   function automatic logic [31:0] sum_ref(input int unsigned len);
      logic [31:0] s;
      s = '0;
      for (int unsigned i = 0; i < len; i++) s = s + 32'(qa[i]) * 32'(qb[i]);
      return s;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_op(input int unsigned idx, input int unsigned len,
                           input int unsigned vmode, input int unsigned cyc);
      logic v;
      case (vmode)
         0:       v = 1'b1;
         1:       v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx < len && v) begin
         bus.op_valid = 1'b1;
         bus.op_a     = qa[idx];
         bus.op_b     = qb[idx];
      end else begin
         bus.op_valid = 1'b0;
         bus.op_a     = 8'($urandom);
         bus.op_b     = 8'($urandom);
      end
   endtask

   // Issues one command, feeds operands, records first res_valid cycle
   // (relative to the command handshake), stalls res_ready, then retires.
   task automatic do_job(input int unsigned len, input int unsigned vmode, input int unsigned rr_wait,
                         output int unsigned lat, output logic [31:0] d, output logic e,
                         output int unsigned took);
      int unsigned cyc, idx, w;
      bit hs;
      w = 0;
      while (!bus.cmd_ready && w < 50) begin
         step();
         w++;
      end
      check_eq("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = len[7:0];
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = 8'($urandom);
      cyc = 1;
      idx = 0;
      while (!bus.res_valid && cyc < 5000) begin
         drive_op(idx, len, vmode, cyc);
         hs = bus.op_valid && bus.op_ready;
         step();
         cyc++;
         if (hs) idx++;
      end
      bus.op_valid = 1'b0;
      check_eq("res_valid_seen", bus.res_valid, 1);
      lat  = cyc;
      d    = bus.res_data;
      e    = bus.res_err;
      took = idx;
      for (int unsigned k = 0; k < rr_wait; k++) begin
         bus.res_ready = 1'b0;
         step();
         check_eq("hold_valid", bus.res_valid, 1);
         check_eq("hold_data", bus.res_data, d);
         check_eq("hold_err", bus.res_err, e);
         check_eq("hold_cmd_ready", bus.cmd_ready, 0);
      end
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check_eq("res_released", bus.res_valid, 0);
      check_eq("cmd_ready_after", bus.cmd_ready, 1);
      check_eq("err_cleared", bus.res_err, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int unsigned lat, took, len, vm, rr, w;
      logic [31:0] d, expd;
      logic        e;
      int          s0, a0, r0, o0;
      logic [63:0] p;

      bus.cmd_valid = 1'b0;
      bus.cmd_len   = '0;
      bus.op_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.res_ready = 1'b0;

      // reset state
      reset = 1'b1;
      step(); step(); step();
      check_eq("rst_ctrl", {bus.cmd_ready, bus.op_ready, bus.res_valid, bus.res_err,
                            bus.busy, bus.pe_reset, bus.pe_start, bus.pe_ack}, 0);
      check_eq("rst_data", bus.res_data, 0);
      reset = 1'b0;
      #1;
      check_eq("post_rst_cmd_ready", bus.cmd_ready, 1);
      check_eq("post_rst_busy", bus.busy, 0);

      // three-element dot product, op_valid tied high
      qa[0] = 2; qb[0] = 3; qa[1] = 4; qb[1] = 5; qa[2] = 1; qb[2] = 7;
      pe_lat = 1;
      s0 = cnt_start; a0 = cnt_ack;
      do_job(3, 0, 0, lat, d, e, took);
      check_eq("t1_data", d, 33);
      check_eq("t1_err", e, 0);
      check_eq("t1_lat", lat, 16);
      check_eq("t1_starts", 64'(cnt_start - s0), 3);
      check_eq("t1_acks", 64'(cnt_ack - a0), 4);

      // empty vector
      r0 = cnt_reset; a0 = cnt_ack; o0 = cnt_opr; s0 = cnt_start;
      do_job(0, 0, 0, lat, d, e, took);
      check_eq("t2_data", d, 0);
      check_eq("t2_lat", lat, 4);
      check_eq("t2_resets", 64'(cnt_reset - r0), 1);
      check_eq("t2_acks", 64'(cnt_ack - a0), 1);
      check_eq("t2_op_ready", 64'(cnt_opr - o0), 0);
      check_eq("t2_starts", 64'(cnt_start - s0), 0);

      // operand gaps and result back-pressure
      qa[0] = 8'($urandom); qb[0] = 8'($urandom); qa[1] = 8'($urandom); qb[1] = 8'($urandom);
      do_job(2, 1, 5, lat, d, e, took);
      check_eq("t3_data", d, sum_ref(2));
      check_eq("t3_took", took, 2);

      // PE never answers after the first start: WAIT timeout
      pe_dead = 1;
      qa[0] = 3; qb[0] = 3;
      do_job(1, 0, 0, lat, d, e, took);
      check_eq("t4_err", e, 1);
      check_eq("t4_data", d, 0);
      check_eq("t4_lat", lat, 6 + TMO);
      // PE never answers the clear: CLR_WAIT timeout
      pe_dead = 2;
      do_job(3, 0, 0, lat, d, e, took);
      check_eq("t4c_err", e, 1);
      check_eq("t4c_data", d, 0);
      check_eq("t4c_lat", lat, 2 + TMO);
      check_eq("t4c_took", took, 0);
      pe_dead = 0;
      qa[0] = 8'($urandom); qb[0] = 8'($urandom); qa[1] = 8'($urandom); qb[1] = 8'($urandom);
      do_job(2, 0, 1, lat, d, e, took);
      check_eq("t4n_err", e, 0);
      check_eq("t4n_data", d, sum_ref(2));

      // reset during WAIT of element 2 of 4
      pe_lat = 3;
      for (int unsigned i = 0; i < 4; i++) begin qa[i] = 8'(i + 9); qb[i] = 8'(i + 1); end
      s0 = cnt_start;
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = 8'd4;
      step();
      bus.cmd_valid = 1'b0;
      bus.op_valid  = 1'b1;
      bus.op_a      = qa[1];
      bus.op_b      = qb[1];
      w = 0;
      while (!((cnt_start - s0) == 2 && bus.busy && !bus.pe_start && !bus.op_ready
               && !bus.pe_ack && !bus.pe_reset) && w < 200) begin
         step();
         w++;
      end
      check_eq("t5_reached_wait", 64'(cnt_start - s0), 2);
      bus.op_valid = 1'b0;
      reset = 1'b1;
      step();
      check_eq("t5_rst_ctrl", {bus.cmd_ready, bus.op_ready, bus.res_valid, bus.res_err,
                               bus.busy, bus.pe_reset, bus.pe_start, bus.pe_ack}, 0);
      check_eq("t5_rst_pe_a", bus.pe_a, 0);
      reset = 1'b0;
      #1;
      check_eq("t5_cmd_ready", bus.cmd_ready, 1);
      check_eq("t5_busy", bus.busy, 0);
      check_eq("t5_res_data", bus.res_data, 0);
      check_eq("t5_pe_b", bus.pe_b, 0);
      pe_lat = 1;
      qa[0] = 255; qb[0] = 255;
      do_job(1, 0, 0, lat, d, e, took);
      check_eq("t5_data", d, 65025);
      check_eq("t5_err", e, 0);

      // wraparound: PE clear preloads 69999 accumulations of 255*255
      p = 64'd65025 * 64'd69999;
      preset_val = p[31:0];
      preset_en  = 1'b1;
      do_job(1, 0, 0, lat, d, e, took);
      check_eq("t6_wrap", d, 256782704);
      preset_en = 1'b0;

      // random jobs
      for (int unsigned j = 0; j < 30; j++) begin
         len    = (j == 29) ? 255 : $urandom_range(0, 12);
         vm     = $urandom_range(0, 2);
         rr     = $urandom_range(0, 3);
         pe_lat = $urandom_range(1, 4);
         for (int unsigned i = 0; i < len; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
         end
         expd = sum_ref(len);
         do_job(len, vm, rr, lat, d, e, took);
         check_eq("rnd_data", d, expd);
         check_eq("rnd_err", e, 0);
         check_eq("rnd_took", took, len);
         if (vm == 0 && pe_lat == 1) check_eq("rnd_lat", lat, 4 * len + 4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pe_mac_sequencer.md
Name: pe_mac_sequencer

Overview:
- Command-driven controller that runs one dot product of cmd_len operand pairs through a single multiply-accumulate processing element.
- Clears the PE, streams operand pairs into it one at a time, and completes the PE's ready/ack handshake for every operation.
- Returns the final accumulated sum on a valid/ready result port.
- Sits between the operand-fetch logic (operand stream) and the PE; one sequencer per PE.

Parameters:
PRECISION, 8, operand width of a and b (unsigned)
OUTPUT_PRECISION, 32, accumulator/result width
LEN_W, 8, width of the vector-length field; max length 2^LEN_W-1
TIMEOUT, 16, max cycles spent waiting for pe_ready before aborting

Ports:
CLK  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_len  in  LEN_W  number of operand pairs in the dot product
op_valid  in  1  operand pair present
op_ready  out  1  sequencer accepts operand pair
op_a  in  PRECISION  operand a
op_b  in  PRECISION  operand b
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_data  out  OUTPUT_PRECISION  accumulated sum
res_err  out  1  result aborted by timeout
busy  out  1  high in every state except IDLE
pe_reset  out  1  PE accumulator clear
pe_start  out  1  PE start_multiply
pe_a  out  PRECISION  operand to PE
pe_b  out  PRECISION  operand to PE
pe_ready  in  1  PE ready flag
pe_ack  out  1  PE acknowledge (PE gives ack priority over reset/start)
pe_s  in  OUTPUT_PRECISION  PE accumulator output

Behaviour:
- Reset values (held while reset=1, regardless of state):
  - all outputs 0; state IDLE; counters 0; res_data 0.
  - A reset mid-operation abandons the job. The PE is not touched; the next command's CLR state cleans it.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_len into len_r, clear elem count and timer, go to CLR.
  - CLR (1 cycle): pe_reset=1, then go to CLR_WAIT.
  - CLR_WAIT: wait for pe_ready=1, then go to CLR_ACK. On timeout go to RESULT with err.
  - CLR_ACK (1 cycle): pe_ack=1. If len_r==0, go to RESULT with res_data=0. Otherwise go to FETCH.
  - FETCH: op_ready=1. On op_valid, register op_a/op_b into pe_a/pe_b and go to MAC.
  - MAC (1 cycle): pe_start=1, then go to WAIT.
  - WAIT: wait for pe_ready=1, then go to ACK. On timeout go to RESULT with err.
  - ACK (1 cycle): pe_ack=1, res_data<=pe_s, count+1. If count+1==len_r go to RESULT, else go to FETCH.
  - RESULT: res_valid=1, holding res_data and res_err stable until res_ready. On res_ready, clear res_err and go to IDLE.
- PE-side signal rules:
  - pe_ack is never asserted in the same cycle as pe_reset or pe_start.
  - pe_reset and pe_start are never asserted together.
  - Each is a single-cycle pulse.
  - pe_a/pe_b hold their value from the FETCH handshake through ACK.
- Other output rules:
  - cmd_ready and op_ready are only high in IDLE and FETCH respectively; no skid buffering.
  - Operands arriving outside FETCH are not consumed.
- Timeout:
  - The wait timer counts cycles spent in CLR_WAIT/WAIT and resets on entry to either state.
  - When it reaches TIMEOUT with pe_ready still 0, go to RESULT with res_err=1.
  - On a WAIT timeout, res_data holds the last captured partial sum. On a CLR_WAIT timeout, res_data=0.
- Arithmetic: accumulation is done by the PE, modulo 2^OUTPUT_PRECISION. The sequencer passes pe_s through unmodified.
- Latency with op_valid tied high and a PE answering in 1 cycle:
  - Command handshake in cycle 0; CLR in cycle 1; CLR_WAIT in cycle 2; CLR_ACK in cycle 3.
  - Each element takes 4 cycles (FETCH, MAC, WAIT, ACK).
  - res_valid first high in cycle 4N+4.
- Stalls: op_valid low stalls in FETCH indefinitely, with no timeout. res_ready low holds RESULT indefinitely.
- Back-to-back commands: cmd_ready rises the cycle after the res handshake.

Test Plan:
- cmd_len=3, ops (2,3),(4,5),(1,7), PE 1-cycle ready, res_ready=1 -> res_data=33, res_err=0, res_valid first in cycle 16 after the cmd handshake; exactly 3 pe_start pulses and 4 pe_ack pulses.
- cmd_len=0 -> one pe_reset and one pe_ack; res_data=0 in cycle 4; op_ready never asserted.
- cmd_len=2, op_valid toggling 1-0-0-1, res_ready low for 5 cycles -> sum correct; res_data/res_valid held stable while stalled; cmd_ready=0 throughout; every operand handshake happens in FETCH.
- PE model never raises ready after the 1st pe_start, TIMEOUT=16, ops (3,3) -> after 16 WAIT cycles res_valid=1, res_err=1, res_data=0 (no ACK capture occurred); next command clears res_err and completes normally.
- reset pulsed during WAIT of element 2 of 4 -> next cycle all outputs 0 and cmd_ready=1; new command cmd_len=1 with (255,255) -> res_data=65025.
- Checker on every cycle: pe_ack & (pe_start|pe_reset) never 1; pe_start & pe_reset never 1; 255*255 accumulated 70000 times with OUTPUT_PRECISION=32 -> res_data=4551750000 mod 2^32 = 256782704.
